// File: rtl/dfe_train_ctrl.sv
// DFE training controller: flushes symbol history, adapts feedback taps by
// sign-sign LMS against known training symbols, then reports lock or failure.
module dfe_train_ctrl #(
   parameter int SIGNAL_RESOLUTION = 8,
   parameter int NUM_TAPS          = 2,
   parameter int TAP_WIDTH         = 8,
   parameter int STEP              = 1,
   parameter int ERR_THRESH        = 8,
   parameter int LOCK_COUNT        = 16,
   parameter int TRAIN_LEN         = 256
) (
   input  logic                                 clk,
   input  logic                                 rstn,
   input  logic                                 start,
   input  logic signed [SIGNAL_RESOLUTION-1:0]  eq_in,
   input  logic                                 eq_valid,
   input  logic signed [SIGNAL_RESOLUTION-1:0]  train_data,
   input  logic                                 train_data_valid,
   output logic [NUM_TAPS*TAP_WIDTH-1:0]        taps,
   output logic                                 taps_valid,
   output logic                                 dfe_en,
   output logic                                 busy,
   output logic                                 locked,
   output logic                                 fail
);

   localparam int SR     = SIGNAL_RESOLUTION;
   localparam int ERR_W  = SR + 1;
   localparam int CNT_W  = $clog2(TRAIN_LEN + 1);
   localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
   localparam int FL_W   = $clog2(NUM_TAPS + 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FLUSH  = 3'd1;
   localparam logic [2:0] S_TRAIN  = 3'd2;
   localparam logic [2:0] S_LOCKED = 3'd3;
   localparam logic [2:0] S_FAIL   = 3'd4;

   localparam logic signed [TAP_WIDTH+1:0] TAP_MAX = (TAP_WIDTH+2)'((2**(TAP_WIDTH-1)) - 1);
   localparam logic signed [TAP_WIDTH+1:0] TAP_MIN = (TAP_WIDTH+2)'(-(2**(TAP_WIDTH-1)));
   localparam logic signed [TAP_WIDTH+1:0] STEP_X  = (TAP_WIDTH+2)'(STEP);

   function automatic logic signed [TAP_WIDTH-1:0] sat_step(
      input logic signed [TAP_WIDTH-1:0] tap,
      input logic                        up
   );
      logic signed [TAP_WIDTH+1:0] sum;
      sum = {{2{tap[TAP_WIDTH-1]}}, tap};
      sum = up ? sum + STEP_X : sum - STEP_X;
      if (sum > TAP_MAX)      sat_step = TAP_MAX[TAP_WIDTH-1:0];
      else if (sum < TAP_MIN) sat_step = TAP_MIN[TAP_WIDTH-1:0];
      else                    sat_step = sum[TAP_WIDTH-1:0];
   endfunction

   function automatic logic [ERR_W-1:0] abs_err(input logic signed [ERR_W-1:0] e);
      abs_err = e[ERR_W-1] ? -e : e;
   endfunction

   logic [2:0]                 state_q, state_d;
   logic signed [SR-1:0]       hist_q [NUM_TAPS];
   logic signed [SR-1:0]       hist_d [NUM_TAPS];
   logic [CNT_W-1:0]           cnt_q, cnt_d;
   logic [GOOD_W-1:0]          good_q, good_d;
   logic [FL_W-1:0]            flush_q, flush_d;
   logic signed [TAP_WIDTH-1:0] taps_q [NUM_TAPS];
   logic signed [TAP_WIDTH-1:0] taps_d [NUM_TAPS];
   logic                       taps_valid_q, dfe_en_q, busy_q, locked_q, fail_q;
   logic                       acc, shift, vld_d, chg;
   logic signed [ERR_W-1:0]    err_c;
   logic signed [ERR_W-1:0]    err_p0;
   logic signed [SR-1:0]       hist_p0 [NUM_TAPS];
   logic                       vld_p0;

   assign acc   = eq_valid & train_data_valid;
   assign err_c = {eq_in[SR-1], eq_in} - {train_data[SR-1], train_data};

   always_comb begin
      state_d = state_q;
      hist_d  = hist_q;
      cnt_d   = cnt_q;
      good_d  = good_q;
      flush_d = flush_q;
      shift   = 1'b0;
      vld_d   = 1'b0;
      case (state_q)
         S_IDLE, S_LOCKED, S_FAIL: begin
            if (start) begin
               state_d = S_FLUSH;
               cnt_d   = '0;
               good_d  = '0;
               flush_d = '0;
               for (int k = 0; k < NUM_TAPS; k++) hist_d[k] = '0;
            end
         end
         S_FLUSH: begin
            if (acc) begin
               shift = 1'b1;
               if (flush_q == FL_W'(NUM_TAPS - 1)) begin
                  state_d = S_TRAIN;
                  flush_d = '0;
               end else begin
                  flush_d = flush_q + FL_W'(1);
               end
            end
         end
         S_TRAIN: begin
            if (acc) begin
               shift  = 1'b1;
               vld_d  = 1'b1;
               good_d = (abs_err(err_c) <= ERR_W'(ERR_THRESH)) ? good_q + GOOD_W'(1) : '0;
               if (cnt_q != CNT_W'(TRAIN_LEN)) cnt_d = cnt_q + CNT_W'(1);
               // Lock takes priority when both limits are hit by the same sample.
               if (good_d == GOOD_W'(LOCK_COUNT))    state_d = S_LOCKED;
               else if (cnt_d == CNT_W'(TRAIN_LEN)) state_d = S_FAIL;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (shift) begin
         for (int k = NUM_TAPS - 1; k > 0; k--) hist_d[k] = hist_q[k-1];
         hist_d[0] = train_data;
      end
   end

   // Tap stage: applies the update captured at the accepting edge one cycle later.
   always_comb begin
      taps_d = taps_q;
      chg    = 1'b0;
      for (int k = 0; k < NUM_TAPS; k++) begin
         if (vld_p0 && (err_p0 != '0) && (hist_p0[k] != '0)) begin
            taps_d[k] = sat_step(taps_q[k], err_p0[ERR_W-1] == hist_p0[k][SR-1]);
         end
         chg = chg | (taps_d[k] != taps_q[k]);
      end
   end

   always_ff @(posedge clk) begin
      if (acc) begin
         err_p0  <= err_c;
         hist_p0 <= hist_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         good_q       <= '0;
         flush_q      <= '0;
         vld_p0       <= 1'b0;
         taps_valid_q <= 1'b0;
         dfe_en_q     <= 1'b0;
         busy_q       <= 1'b0;
         locked_q     <= 1'b0;
         fail_q       <= 1'b0;
         for (int k = 0; k < NUM_TAPS; k++) begin
            hist_q[k] <= '0;
            taps_q[k] <= '0;
         end
      end else begin
         state_q      <= state_d;
         hist_q       <= hist_d;
         cnt_q        <= cnt_d;
         good_q       <= good_d;
         flush_q      <= flush_d;
         vld_p0       <= vld_d;
         taps_q       <= taps_d;
         taps_valid_q <= chg;
         dfe_en_q     <= (state_d == S_TRAIN) || (state_d == S_LOCKED);
         busy_q       <= (state_d == S_FLUSH) || (state_d == S_TRAIN);
         locked_q     <= (state_d == S_LOCKED);
         fail_q       <= (state_d == S_FAIL);
      end
   end

   for (genvar g = 0; g < NUM_TAPS; g++) begin : g_taps
      assign taps[g*TAP_WIDTH +: TAP_WIDTH] = taps_q[g];
   end

   assign taps_valid = taps_valid_q;
   assign dfe_en     = dfe_en_q;
   assign busy       = busy_q;
   assign locked     = locked_q;
   assign fail       = fail_q;

endmodule

// File: tb/tb_dfe_train_ctrl.sv
// Self-checking bench for dfe_train_ctrl: randomized training runs compared
// cycle by cycle against a transaction-level model of the training rules.
module tb_dfe_train_ctrl;

   localparam int SR   = 8;
   localparam int NT   = 2;
   localparam int TW   = 8;
   localparam int STEP = 1;
   localparam int ETH  = 8;
   localparam int LC   = 16;
   localparam int TL   = 256;
   localparam int VW   = NT*TW + 5;

   logic                 clk = 1'b0;
   logic                 rstn = 1'b0;
   logic                 start = 1'b0;
   logic signed [SR-1:0] eq_in = '0;
   logic                 eq_valid = 1'b0;
   logic signed [SR-1:0] train_data = '0;
   logic                 train_data_valid = 1'b0;
   logic [NT*TW-1:0]     taps;
   logic                 taps_valid, dfe_en, busy, locked, fail;

   dfe_train_ctrl #(
      .SIGNAL_RESOLUTION(SR), .NUM_TAPS(NT), .TAP_WIDTH(TW), .STEP(STEP),
      .ERR_THRESH(ETH), .LOCK_COUNT(LC), .TRAIN_LEN(TL)
   ) dut (
      .clk(clk), .rstn(rstn), .start(start),
      .eq_in(eq_in), .eq_valid(eq_valid),
      .train_data(train_data), .train_data_valid(train_data_valid),
      .taps(taps), .taps_valid(taps_valid), .dfe_en(dfe_en),
      .busy(busy), .locked(locked), .fail(fail)
   );

   always #5 clk = ~clk;

   wire [VW-1:0] obs = {taps, taps_valid, dfe_en, busy, locked, fail};

   int checks = 0;
   int errors = 0;

   // Reference model: phase name, integer taps, symbol history as a queue.
   string m_mode = "idle";
   int    m_taps [NT];
   int    m_hist [$];
   int    m_good, m_cnt, m_fill;
   bit    m_pend, m_tv;
   int    m_perr;
   int    m_phist [NT];

   function automatic int sgn(input int v);
      if (v > 0) return 1;
      if (v < 0) return -1;
      return 0;
   endfunction

   function automatic int rsym();
      case ($urandom % 4)
         0:       return -84;
         1:       return -28;
         2:       return 28;
         default: return 84;
      endcase
   endfunction

   task automatic model_reset();
      m_mode = "idle";
      m_hist = {};
      for (int k = 0; k < NT; k++) begin
         m_taps[k] = 0;
         m_hist.push_back(0);
      end
      m_good = 0; m_cnt = 0; m_fill = 0; m_pend = 0; m_tv = 0; m_perr = 0;
   endtask

   task automatic model_edge(input bit r, input bit st, input bit ev, input bit tv,
                             input int eq, input int td);
      int nt;
      if (!r) begin
         model_reset();
         return;
      end
      m_tv = 0;
      if (m_pend) begin
         for (int k = 0; k < NT; k++) begin
            if (m_perr != 0 && m_phist[k] != 0) begin
               nt = m_taps[k] + ((sgn(m_perr) == sgn(m_phist[k])) ? STEP : -STEP);
               if (nt > 127)  nt = 127;
               if (nt < -128) nt = -128;
               if (nt != m_taps[k]) m_tv = 1;
               m_taps[k] = nt;
            end
         end
         m_pend = 0;
      end
      if (m_mode == "idle" || m_mode == "locked" || m_mode == "fail") begin
         if (st) begin
            m_mode = "flush";
            m_good = 0; m_cnt = 0; m_fill = 0;
            for (int k = 0; k < NT; k++) m_hist[k] = 0;
         end
      end else if (ev && tv) begin
         if (m_mode == "train") begin
            m_perr = eq - td;
            m_pend = 1;
            for (int k = 0; k < NT; k++) m_phist[k] = m_hist[k];
            m_good = ((m_perr <= ETH) && (m_perr >= -ETH)) ? m_good + 1 : 0;
            m_cnt++;
            if (m_good == LC)      m_mode = "locked";
            else if (m_cnt == TL)  m_mode = "fail";
         end else begin
            m_fill++;
            if (m_fill == NT) m_mode = "train";
         end
         m_hist.push_front(td);
         void'(m_hist.pop_back());
      end
   endtask

   function automatic logic [VW-1:0] exp_vec();
      logic [NT*TW-1:0] t;
      for (int k = 0; k < NT; k++) t[k*TW +: TW] = TW'(m_taps[k]);
      return {t, m_tv, (m_mode == "train" || m_mode == "locked"),
              (m_mode == "flush" || m_mode == "train"),
              (m_mode == "locked"), (m_mode == "fail")};
   endfunction

   task automatic cyc(input bit r, input bit st, input bit ev, input bit tv,
                      input int eq, input int td);
      rstn = r; start = st; eq_valid = ev; train_data_valid = tv;
      eq_in = SR'(eq); train_data = SR'(td);
      @(posedge clk);
      model_edge(r, st, ev, tv, eq, td);
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         cyc(0, 1, 1'($urandom % 2), 1'($urandom % 2), rsym(), rsym());
         checks++;
         if (obs !== '0) begin
            errors++;
            $display("FAIL reset cyc %0d: got %h want %h", i, obs, {VW{1'b0}});
         end
      end
   endtask

   task automatic test_lock();
      int pat [4] = '{28, -84, 84, -28};
      int n = 0;
      int tv_seen = 0;
      cyc(1, 1, 0, 0, 0, 0);
      while (n < NT + LC) begin
         if ($urandom % 3 == 0) cyc(1, 0, 0, 0, rsym(), rsym());
         else begin
            cyc(1, 0, 1, 1, pat[n % 4], pat[n % 4]);
            n++;
         end
         tv_seen += int'(taps_valid);
         checks++;
         if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL lock n=%0d: got %h want %h", n, obs, exp_vec());
         end
         if (n == NT + LC - 1) begin
            checks++;
            if (locked !== 1'b0) begin
               errors++;
               $display("FAIL lock_early: got %b want 0", locked);
            end
         end
      end
      cyc(1, 0, 0, 0, 0, 0);
      tv_seen += int'(taps_valid);
      checks++;
      if (locked !== 1'b1 || tv_seen != 0) begin
         errors++;
         $display("FAIL lock_final: locked %b taps_valid pulses %0d want 1 and 0", locked, tv_seen);
      end
   endtask

   task automatic test_adapt();
      int td;
      cyc(1, 1, 0, 0, 0, 0);
      for (int i = 0; i < NT; i++) begin
         td = rsym();
         cyc(1, 0, 1, 1, td, td);
      end
      for (int i = 0; i < 40; i++) begin
         if ($urandom % 4 == 0) cyc(1, 0, 0, 0, rsym(), rsym());
         td = rsym();
         cyc(1, 0, 1, 1, td + 20 * sgn(m_hist[0]), td);
         checks++;
         if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL adapt i=%0d: got %h want %h", i, obs, exp_vec());
         end
      end
      cyc(1, 0, 0, 0, 0, 0);
      checks++;
      if ($signed(taps[TW-1:0]) !== 8'sd40) begin
         errors++;
         $display("FAIL adapt_tap0: got %0d want 40", $signed(taps[TW-1:0]));
      end
   endtask

   task automatic test_saturation();
      int tv_late = 0;
      for (int i = 0; i < 190; i++) begin
         cyc(1, 0, 1, 1, 104, 84);
         if (i >= 170) tv_late += int'(taps_valid);
         checks++;
         if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL sat i=%0d: got %h want %h", i, obs, exp_vec());
         end
      end
      cyc(1, 0, 0, 0, 0, 0);
      tv_late += int'(taps_valid);
      checks++;
      if (taps !== {8'sd127, 8'sd127} || tv_late != 0) begin
         errors++;
         $display("FAIL sat_hold: taps %h pulses %0d want 7f7f and 0", taps, tv_late);
      end
   endtask

   task automatic test_abort();
      for (int i = 0; i < 6; i++) begin
         cyc(1, 1'($urandom % 2), 1'(i % 2), 1'((i + 1) % 2), rsym(), rsym());
         checks++;
         if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL gaps i=%0d: got %h want %h", i, obs, exp_vec());
         end
      end
      cyc(0, 0, 1, 1, 104, 84);
      checks++;
      if (obs !== '0 || obs !== exp_vec()) begin
         errors++;
         $display("FAIL abort: got %h want %h", obs, {VW{1'b0}});
      end
   endtask

   task automatic test_fail();
      int td;
      int n = 0;
      cyc(1, 1, 0, 0, 0, 0);
      for (int i = 0; i < NT; i++) begin
         td = rsym();
         cyc(1, 0, 1, 1, td, td);
      end
      while (n < TL) begin
         case ($urandom % 5)
            0: cyc(1, 1'($urandom % 2), 1, 0, rsym(), rsym());
            1: cyc(1, 1'($urandom % 2), 0, 1, rsym(), rsym());
            default: begin
               td = rsym();
               cyc(1, 0, 1, 1, td + 40, td);
               n++;
            end
         endcase
         checks++;
         if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL fail_run n=%0d: got %h want %h", n, obs, exp_vec());
         end
         if (n == TL - 1) begin
            checks++;
            if (fail !== 1'b0 || dfe_en !== 1'b1) begin
               errors++;
               $display("FAIL fail_early: fail %b dfe_en %b want 0 1", fail, dfe_en);
            end
         end
      end
      checks++;
      if (fail !== 1'b1 || dfe_en !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL fail_at_256: fail %b dfe_en %b busy %b want 1 0 0", fail, dfe_en, busy);
      end
   endtask

   task automatic test_back_to_back();
      int td;
      cyc(1, 1, 0, 0, 0, 0);
      checks++;
      if (busy !== 1'b1 || fail !== 1'b0 || obs !== exp_vec()) begin
         errors++;
         $display("FAIL restart: busy %b fail %b want 1 0", busy, fail);
      end
      for (int i = 0; i < NT + 4; i++) begin
         td = rsym();
         cyc(1, 0, 1, 1, td + 3, td);
         checks++;
         if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL b2b i=%0d: got %h want %h", i, obs, exp_vec());
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_lock();
      test_adapt();
      test_saturation();
      test_abort();
      test_fail();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
